// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: drives one column low at a time, debounces the row response and
// shifts each accepted key code into a 32-bit digit word.
module hex_keypad_scanner #(
  parameter int unsigned SCAN_DIV  = 150000,
  parameter int unsigned DEB_TICKS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_row,
  output logic [3:0]  key_col,
  input  logic        clr,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [31:0] data
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DebW = $clog2(DEB_TICKS + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);
  localparam logic [DebW-1:0] DebMax = DebW'(DEB_TICKS);

  typedef enum logic [1:0] {StScan, StDebounce, StPressed, StRelease} state_e;

  state_e         state_q, state_d;
  logic [3:0]     sync_q, rs_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic           drive_q, drive_d;
  logic [1:0]     col_q, col_d;
  logic [1:0]     row_q, row_d;
  logic [DebW-1:0] deb_q, deb_d, deb_inc;
  logic           valid_q, valid_d;
  logic [3:0]     code_q, code_d;
  logic [31:0]    data_q, data_d;
  logic           tick;
  logic [1:0]     first_row;
  logic [3:0]     press_code;

  always_comb begin
    tick       = (cnt_q == CntMax);
    cnt_d      = tick ? '0 : cnt_q + 1'b1;
    deb_inc    = deb_q + 1'b1;
    press_code = {row_q, col_q};
    state_d    = state_q;
    drive_d    = drive_q;
    col_d      = col_q;
    row_d      = row_q;
    deb_d      = deb_q;
    valid_d    = 1'b0;
    code_d     = code_q;
    data_d     = clr ? '0 : data_q;

    // Row 0 has priority when several rows read low.
    if (!rs_q[0])      first_row = 2'd0;
    else if (!rs_q[1]) first_row = 2'd1;
    else if (!rs_q[2]) first_row = 2'd2;
    else               first_row = 2'd3;

    // First tick after reset only starts driving column 0; rows were not yet meaningful.
    if (tick && !drive_q) begin
      drive_d = 1'b1;
    end else begin
      unique case (state_q)
        StScan: begin
          if (tick) begin
            if (rs_q == 4'hF) begin
              col_d = col_q + 2'd1;
            end else begin
              row_d   = first_row;
              deb_d   = DebW'(1);
              state_d = (DEB_TICKS == 1) ? StPressed : StDebounce;
            end
          end
        end
        StDebounce: begin
          if (tick) begin
            if (!rs_q[row_q]) begin
              deb_d = deb_inc;
              if (deb_inc == DebMax) state_d = StPressed;
            end else begin
              deb_d   = '0;
              state_d = StScan;
            end
          end
        end
        StPressed: begin
          valid_d = 1'b1;
          code_d  = press_code;
          data_d  = clr ? {28'b0, press_code} : {data_q[27:0], press_code};
          deb_d   = '0;
          state_d = StRelease;
        end
        StRelease: begin
          if (tick) begin
            if (rs_q == 4'hF) begin
              deb_d = deb_inc;
              if (deb_inc == DebMax) begin
                deb_d   = '0;
                state_d = StScan;
              end
            end else begin
              deb_d = '0;
            end
          end
        end
        default: state_d = StScan;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StScan;
      sync_q  <= 4'hF;
      rs_q    <= 4'hF;
      cnt_q   <= '0;
      drive_q <= 1'b0;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      deb_q   <= '0;
      valid_q <= 1'b0;
      code_q  <= 4'h0;
      data_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      sync_q  <= key_row;
      rs_q    <= sync_q;
      cnt_q   <= cnt_d;
      drive_q <= drive_d;
      col_q   <= col_d;
      row_q   <= row_d;
      deb_q   <= deb_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      data_q  <= data_d;
    end
  end

  // key_valid is registered so it coincides with the updated key_code and data.
  assign key_col   = drive_q ? ~(4'b0001 << col_q) : 4'hF;
  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign data      = data_q;

endmodule
